// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency external multiplier among N_REQ requesters.
// A {valid,id} tag travels alongside each operation and steers the result to its requester.
module mult_arbiter #(
    parameter int N_REQ = 3,
    parameter int LAT   = 11,
    parameter int W     = 51,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW   = $clog2(LAT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [2*W-1:0]     resp_data,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic [2*W-1:0]     mul_result,
    output logic [CW-1:0]      inflight
);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_id;
    logic          hs;

    // vld_pipe[0] rides with the registered operands; stage k matches multiplier stage k-1,
    // so vld_pipe[LAT] is set exactly while mul_result carries that operation's product.
    logic [LAT:0]  vld_pipe;
    logic [PW-1:0] id_pipe [LAT:0];

    always_comb begin
        int idx;
        idx       = 0;
        req_ready = '0;
        gnt_id    = '0;
        hs        = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!hs && !rst && req_valid[idx]) begin
                hs     = 1'b1;
                gnt_id = PW'(idx);
            end
        end
        req_ready[gnt_id] = hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            vld_pipe   <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            inflight   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-1:0], hs};
            if (hs) begin
                rr_ptr <= (gnt_id == PW'(N_REQ - 1)) ? '0 : gnt_id + PW'(1);
                mul_a  <= req_a[int'(gnt_id)*W +: W];
                mul_b  <= req_b[int'(gnt_id)*W +: W];
            end
            resp_valid <= '0;
            if (vld_pipe[LAT]) begin
                resp_valid[id_pipe[LAT]] <= 1'b1;
                resp_data                <= mul_result;
            end
            // An operation stops counting once its product emerges from the multiplier.
            case ({hs, vld_pipe[LAT-1]})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        id_pipe[0] <= gnt_id;
        for (int k = 1; k <= LAT; k++) id_pipe[k] <= id_pipe[k-1];
    end

endmodule
